// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared constants and the sideband record for the partial-
//               product reduction pipeline.
//                 XLEN       - width of the returned product half
//                 PP_WIDTH   - width of one partial product / full product
//                 sideband_t - {valid, neg, higher} carried with every stage
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int XLEN     = 32;
    localparam int PP_WIDTH = 64;

    // neg holds neg_a XOR neg_b, so the output stage only tests one bit.
    typedef struct packed {
        logic valid;
        logic neg;
        logic higher;
    } sideband_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_add_level.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_level
// Description : One level of the reduction tree: N/2 pairwise 64-bit adders
//               (modulo 2^64) with the sideband passed alongside.  With
//               REG_EN = 1 the sums and sideband are registered; with
//               REG_EN = 0 the level is purely combinational.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset (valid bit only)
//               i_flush - drop the operation entering this register
//               i_terms - N input terms, term k at [64k+63:64k]
//               i_sb    - sideband of the incoming operation
//               o_sums  - N/2 pairwise sums
//               o_sb    - sideband of the outgoing operation
// Revision    : 1.0 - initial release
// ============================================================================
module mul_add_level
    import mul_pkg::*;
#(
    parameter int N      = 2,
    parameter bit REG_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic [N*PP_WIDTH-1:0]        i_terms,
    input  sideband_t                    i_sb,
    output logic [(N/2)*PP_WIDTH-1:0]    o_sums,
    output sideband_t                    o_sb
);

    logic [(N/2)*PP_WIDTH-1:0] w_sums;

    for (genvar k = 0; k < N/2; k++) begin : g_add
        assign w_sums[k*PP_WIDTH +: PP_WIDTH] =
            i_terms[(2*k)*PP_WIDTH +: PP_WIDTH] + i_terms[(2*k+1)*PP_WIDTH +: PP_WIDTH];
    end

    if (REG_EN) begin : g_reg
        logic                      r_valid;
        logic                      r_neg;
        logic                      r_higher;
        logic [(N/2)*PP_WIDTH-1:0] r_sums;

        // Data only loads with a live operation, so idle cycles leave the
        // previous contents untouched.
        always_ff @(posedge clk) begin
            if (rst || i_flush) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= i_sb.valid;
            end
            if (i_sb.valid) begin
                r_sums   <= w_sums;
                r_neg    <= i_sb.neg;
                r_higher <= i_sb.higher;
            end
        end

        assign o_sums = r_sums;
        assign o_sb   = '{valid: r_valid, neg: r_neg, higher: r_higher};
    end else begin : g_comb
        logic w_unused_ok;
        assign w_unused_ok = &{1'b0, clk, rst, i_flush};
        assign o_sums      = w_sums;
        assign o_sb        = i_sb;
    end

endmodule : mul_add_level
`default_nettype wire

// File: rtl/mul_reduce.sv
`default_nettype none
// ============================================================================
// Module      : mul_reduce
// Description : Sums SIZE 64-bit partial products with a pairwise adder tree,
//               applies the operand sign (two's-complement negate when
//               neg_a ^ neg_b), and returns the upper or lower 32-bit half.
//               One operation per cycle, no backpressure, fixed latency.
// Config      : MUL_REDUCE_LEVEL_REG_EN defined   -> register after every
//               tree level + output stage, latency log2(SIZE)+1.
//               MUL_REDUCE_LEVEL_REG_EN undefined -> combinational tree into
//               one register + output stage, latency 2.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               start_i   - a partial-product set is present this cycle
//               partial_i - SIZE terms, term k at [64k+63:64k]
//               sign_i    - {neg_a, neg_b}
//               higher_i  - 1: product[63:32], 0: product[31:0]
//               flush_i   - discard every in-flight operation
//               valid_o   - one-cycle pulse, result_o holds a new result
//               result_o  - selected product half (held between pulses)
//               busy_o    - an operation sits in a tree stage register
// Revision    : 1.0 - initial release
// ============================================================================
module mul_reduce
    import mul_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [PP_WIDTH*SIZE-1:0] partial_i,
    input  logic [1:0]               sign_i,
    input  logic                     higher_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [XLEN-1:0]          result_o,
    output logic                     busy_o
);

    localparam int c_LEVELS = $clog2(SIZE);
`ifdef MUL_REDUCE_LEVEL_REG_EN
    localparam bit c_REG_EVERY_LEVEL = 1'b1;
`else
    localparam bit c_REG_EVERY_LEVEL = 1'b0;
`endif

    if (!(SIZE >= 2 && SIZE <= 32 && (SIZE & (SIZE - 1)) == 0)) begin : g_size_check
        $error("mul_reduce: SIZE must be a power of two in 2..32");
    end

    sideband_t             w_sb_head;
    logic [c_LEVELS-1:0]   w_stage_valid;
    logic [PP_WIDTH-1:0]   w_sum;
    logic [PP_WIDTH-1:0]   w_product;
    sideband_t             w_root_sb;
    logic                  w_take;
    logic                  r_valid;
    logic [XLEN-1:0]       r_result;

    assign w_sb_head = '{valid: start_i, neg: sign_i[1] ^ sign_i[0], higher: higher_i};

    // Level j reduces SIZE>>j terms to half as many.  When the levels are
    // not individually registered, only the last one carries a register so
    // the whole tree settles into a single stage.
    for (genvar j = 0; j < c_LEVELS; j++) begin : g_level
        localparam int c_N   = SIZE >> j;
        localparam bit c_REG = c_REG_EVERY_LEVEL || (j == c_LEVELS - 1);

        logic [c_N*PP_WIDTH-1:0]     w_in;
        sideband_t                   w_sb_in;
        logic [(c_N/2)*PP_WIDTH-1:0] w_sums;
        sideband_t                   w_sb_out;

        if (j == 0) begin : g_src_input
            assign w_in    = partial_i;
            assign w_sb_in = w_sb_head;
        end else begin : g_src_prev
            assign w_in    = g_level[j-1].w_sums;
            assign w_sb_in = g_level[j-1].w_sb_out;
        end

        mul_add_level #(
            .N      (c_N),
            .REG_EN (c_REG)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush_i),
            .i_terms (w_in),
            .i_sb    (w_sb_in),
            .o_sums  (w_sums),
            .o_sb    (w_sb_out)
        );

        assign w_stage_valid[j] = c_REG ? w_sb_out.valid : 1'b0;
    end

    assign w_sum     = g_level[c_LEVELS-1].w_sums;
    assign w_root_sb = g_level[c_LEVELS-1].w_sb_out;
    assign w_product = w_root_sb.neg ? (~w_sum + 64'd1) : w_sum;

    // A flushed operation must not disturb result_o, which holds between
    // pulses.
    assign w_take = w_root_sb.valid && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= w_take;
            if (w_take) begin
                r_result <= w_root_sb.higher ? w_product[63:32] : w_product[31:0];
            end
        end
    end

    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign busy_o   = |w_stage_valid;

endmodule : mul_reduce
`default_nettype wire

// File: tb/tb_mul_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_reduce
// Description : Self-checking bench for mul_reduce (SIZE = 16).  A reference
//               model computes each result from plain arithmetic and queues
//               it with its due cycle; a compare process checks valid_o,
//               result_o and busy_o every cycle.  Directed scenarios add
//               hand-computed literal expectations and latency checks.
//               Expected latency follows MUL_REDUCE_LEVEL_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_reduce;

    localparam int SIZE = 16;
    localparam int W    = SIZE * 64;
`ifdef MUL_REDUCE_LEVEL_REG_EN
    localparam int L = 5;
`else
    localparam int L = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [W-1:0]  partial_i = '0;
    logic [1:0]    sign_i = 2'b00;
    logic          higher_i = 1'b0;
    logic          flush_i = 1'b0;
    wire           valid_o;
    wire  [31:0]   result_o;
    wire           busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_reduce #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .partial_i (partial_i),
        .sign_i    (sign_i),
        .higher_i  (higher_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .busy_o    (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [W-1:0] pp, input logic [1:0] sg,
                                                 input logic hi);
        logic [63:0] s;
        s = 64'd0;
        for (int k = 0; k < SIZE; k++) s = s + pp[k*64 +: 64];
        if (sg[1] ^ sg[0]) s = 64'd0 - s;
        return hi ? s[63:32] : s[31:0];
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          n = 0;
    logic [31:0] last_res = 32'd0;
    bit          chk_en = 1'b0;

    // Inputs seen at negedge n are sampled at posedge n+1; their result is
    // visible at negedge n+L.
    always @(negedge clk) begin
        bit ev;
        n++;
        if (chk_en) begin
            ev = (q.size() != 0) && (q[0].due == n);
            check("valid_o", valid_o, ev);
            if (ev) begin
                check("result_o", result_o, q[0].val);
                last_res = q[0].val;
                void'(q.pop_front());
            end else begin
                check("result_hold", result_o, last_res);
            end
            check("busy_o", busy_o, q.size() != 0);
        end
        if (rst) begin
            q.delete();
            last_res = 32'd0;
            chk_en   = 1'b1;
        end else if (flush_i) begin
            q.delete();
        end else if (start_i) begin
            q.push_back(exp_t'{n + L, model_result(partial_i, sign_i, higher_i)});
        end
    end

    int pulses = 0;
    always @(negedge clk) if (valid_o === 1'b1) pulses++;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] pp, input logic [1:0] sg, input logic hi);
        start_i   = 1'b1;
        partial_i = pp;
        sign_i    = sg;
        higher_i  = hi;
    endtask

    // Idle inputs carry junk that the design must ignore.
    task automatic idle();
        start_i   = 1'b0;
        flush_i   = 1'b0;
        partial_i = {SIZE{64'hA5A5_5A5A_0F0F_F0F0}};
        sign_i    = 2'b11;
        higher_i  = ~higher_i;
    endtask

    // Called at the negedge of the issue cycle.
    task automatic measure(input string name, input logic [31:0] exp_res);
        int lat;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 20) begin
            tick();
            if (lat == 0) idle();
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, L);
        check({name, "_result"}, result_o, exp_res);
    endtask

    function automatic logic [W-1:0] pattern(input int i, input logic [63:0] base);
        logic [W-1:0] v;
        for (int k = 0; k < SIZE; k++)
            v[k*64 +: 64] = {32'(i * 32'h0101_0101 + k), 32'hDEAD_0000 ^ 32'(i << 8) ^ 32'(k * 32'h9E37)};
        v[63:0] = base + 64'(i);
        return v;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0] pp_small, pp_one, pp_ff, pp_three, pp_rst;
        int p0, exp_p;

        pp_small = '0;
        pp_small[63:0] = 64'h6;
        pp_one   = {SIZE{64'h0000_0001_0000_0000}};
        pp_ff    = {SIZE{64'hFFFF_FFFF_FFFF_FFFF}};
        pp_three = {SIZE{64'h0000_0000_0000_0003}};
        pp_rst   = '0;
        pp_rst[63:0] = 64'h0000_0007_0000_0009;

        // Pin the model with hand-computed values.
        check("model_small", model_result(pp_small, 2'b00, 1'b0), 32'h0000_0006);
        check("model_neg",   model_result(pp_one, 2'b10, 1'b1), 32'hFFFF_FFF0);
        check("model_pos",   model_result(pp_one, 2'b11, 1'b1), 32'h0000_0010);
        check("model_wrap",  model_result(pp_ff, 2'b00, 1'b0), 32'hFFFF_FFF0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_result", result_o, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // Single operations.
        drive(pp_small, 2'b00, 1'b0);
        @(negedge clk);
        measure("small", 32'h0000_0006);
        tick();
        drive(pp_one, 2'b10, 1'b1);
        @(negedge clk);
        measure("neg_hi", 32'hFFFF_FFF0);
        tick();
        drive(pp_one, 2'b11, 1'b1);
        @(negedge clk);
        measure("pos_hi", 32'h0000_0010);
        tick();
        drive(pp_ff, 2'b00, 1'b0);
        @(negedge clk);
        measure("wrap", 32'hFFFF_FFF0);
        tick();

        // Eight back-to-back operations, alternating higher_i.
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            drive(pattern(i, 64'hFFFF_FFF0_0000_0000), 2'(i), i[0]);
            tick();
        end
        idle();
        repeat (L + 2) @(negedge clk);
        #1;
        check("b2b_pulses", pulses - p0, 8);
        tick();

        // Three in flight, then start together with flush.
        p0 = pulses;
        drive(pattern(20, 64'h1), 2'b01, 1'b0);
        tick();
        drive(pattern(21, 64'h2), 2'b00, 1'b1);
        tick();
        drive(pattern(22, 64'h3), 2'b10, 1'b0);
        tick();
        drive(pattern(23, 64'h4), 2'b00, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(pp_three, 2'b00, 1'b0);
        @(negedge clk);
        check("flush_next_valid", valid_o, 1'b0);
        measure("post_flush", 32'h0000_0030);
        #1;
        exp_p = 1;
        for (int j = 0; j < 3; j++) if (j + L <= 3) exp_p++;
        check("flush_pulses", pulses - p0, exp_p);
        tick();

        // Reset mid-stream with start_i held high.
        for (int i = 0; i < 3; i++) begin
            drive(pattern(30 + i, 64'h5), 2'(i), i[0]);
            tick();
        end
        drive(pattern(40, 64'h6), 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_result", result_o, 32'd0);
        tick();
        drive(pp_rst, 2'b01, 1'b1);
        @(negedge clk);
        measure("post_rst", 32'hFFFF_FFF8);
        tick();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mul_reduce
`default_nettype wire

// File: doc/mul_reduce.md
MUL_REDUCE -- requirements
Module: mul_reduce

Interface
REQ-001 SIZE, 16, number of 64-bit partial products; power of two, 2..32; any other value SHALL fail elaboration.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  a registered partial-product set is present this cycle.
REQ-005 partial_i  input  64*SIZE  partial products; term k occupies bits [64k+63:64k].
REQ-006 sign_i  input  2  {neg_a, neg_b}; operand-magnitude signs from upstream.
REQ-007 higher_i  input  1  1 = return product bits [63:32]; 0 = return bits [31:0].
REQ-008 flush_i  input  1  discard every in-flight operation.
REQ-009 valid_o  output  1  result_o holds a finished result this cycle (one-cycle pulse per operation).
REQ-010 result_o  output  32  selected product half.
REQ-011 busy_o  output  1  at least one operation is in flight (excludes the valid_o cycle).

Function
REQ-012 Block SHALL sum all SIZE terms modulo 2^64 with a pairwise adder tree of log2(SIZE) levels.
REQ-013 Product SHALL equal the two's-complement negation of the sum when neg_a XOR neg_b = 1; otherwise it SHALL equal the sum.
REQ-014 result_o SHALL be product[63:32] when higher_i = 1, else product[31:0]; the selection SHALL be taken from the sideband of the same operation.
REQ-015 start_i, sign_i and higher_i SHALL travel with their data through every stage as a valid bit plus sideband; no operation SHALL overtake or merge with another.
REQ-016 Throughput SHALL be one operation per cycle, with no backpressure; start_i SHALL be accepted every cycle.
REQ-017 Latency from start_i to valid_o SHALL be L cycles (see REQ-024/025), constant and data-independent.
REQ-018 When start_i = 0, stage data registers SHALL hold their values; valid bits SHALL advance as 0.
REQ-019 result_o SHALL hold its last value while valid_o = 0.
REQ-020 flush_i = 1 SHALL clear every stage valid bit on the next edge, including an operation offered on the same cycle (flush wins over start_i); valid_o SHALL be 0 on the following cycle.
REQ-021 An operation offered on the cycle after flush_i SHALL complete normally after L cycles.
REQ-022 Overflow beyond bit 63 SHALL be discarded silently; there SHALL be no saturation and no error flag.

Reset
REQ-023 While rst = 1 at an edge, all valid bits, valid_o, busy_o and result_o SHALL become 0, and rst SHALL dominate flush_i and start_i; data registers other than result_o need not be reset.

Configuration
REQ-024 MUL_REDUCE_LEVEL_REG_EN defined: a register SHALL follow every tree level plus one output stage for negate/select, so L = log2(SIZE)+1 (5 for SIZE = 16).
REQ-025 MUL_REDUCE_LEVEL_REG_EN undefined: the tree SHALL be combinational into one register, followed by the output stage, so L = 2 for every SIZE; function is otherwise identical.

Structure
REQ-026 Shared package mul_pkg SHALL hold XLEN = 32, PP_WIDTH = 64 and the sideband record type {valid, neg, higher}.
REQ-027 One sub-module, mul_add_level, SHALL implement one tree level: N/2 pairwise 64-bit adders with a sideband pass-through and an optional output register selected by a parameter.

Verification
REQ-028 SIZE=16, term0 = 0x0000_0000_0000_0006, others 0, sign 00, higher 0 -> after L cycles valid_o = 1, result_o = 0x0000_0006.
REQ-029 All 16 terms = 0x0000_0001_0000_0000, sign 10, higher 1 -> product = -0x10_0000_0000, result_o = 0xFFFF_FFF0; same with sign 11 -> 0x0000_0010.
REQ-030 Back-to-back start_i for 8 cycles with distinct values and alternating higher_i -> 8 consecutive valid_o pulses, in order, each matching a scoreboard model.
REQ-031 Three operations in flight, then flush_i with start_i on the same cycle -> no valid_o for these 4 operations; a start one cycle later -> valid_o after exactly L cycles.
REQ-032 rst asserted mid-stream with start_i = 1 -> the next cycle valid_o = 0, busy_o = 0, result_o = 0; first post-reset operation completes after L cycles.
REQ-033 All scenarios SHALL run with MUL_REDUCE_LEVEL_REG_EN both defined and undefined, checking L = 5 and L = 2 respectively.
